// File: rtl/jk_pkg.sv
// Shared encodings for the JK flip-flop driver: request ops, FSM states and
// the op-to-J/K table used while a request is being driven.
package jk_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Returns {j, k} for the given op.
  function automatic logic [1:0] op_jk(input op_t op);
    logic [1:0] jk;
    case (op)
      OP_HOLD:   jk = 2'b00;
      OP_RESET:  jk = 2'b01;
      OP_SET:    jk = 2'b10;
      OP_TOGGLE: jk = 2'b11;
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_model.sv
// Reference behaviour of a JK flip-flop: next Q for a given op and current Q.
module jk_model
  import jk_pkg::*;
(
  input  op_t  op,
  input  logic q,
  output logic q_next
);

  always_comb begin
    q_next = q;
    case (op)
      OP_HOLD:   q_next = q;
      OP_RESET:  q_next = 1'b0;
      OP_SET:    q_next = 1'b1;
      OP_TOGGLE: q_next = ~q;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/jk_driver.sv
// Drives an external JK flip-flop for N edges per request and checks the
// returned Q against a model, counting mismatches.
module jk_driver
  import jk_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [3:0]       req_count,
  output logic             j,
  output logic             k,
  input  logic             q_in,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t     state, state_nxt;
  op_t        op_q;
  logic [4:0] remaining;
  logic       exp_q, exp_q_nxt;
  logic       cmp_en;
  logic       accept;
  logic       mismatch;

  jk_model u_model (
    .op     (op_q),
    .q      (exp_q),
    .q_next (exp_q_nxt)
  );

  assign req_ready = (state == ST_IDLE);
  assign done      = (state == ST_DONE);
  assign accept    = (state == ST_IDLE) && req_valid;
  assign mismatch  = cmp_en && (q_in != exp_q);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nxt = ST_DRIVE;
      ST_DRIVE: if (remaining <= 5'd1) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Compares lag the drive window by one edge: Q returns one cycle after J/K.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_HOLD;
      remaining <= '0;
      exp_q     <= 1'b0;
      cmp_en    <= 1'b0;
      j         <= 1'b0;
      k         <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state  <= state_nxt;
      cmp_en <= (state == ST_DRIVE);
      if (accept) begin
        op_q      <= op_t'(req_op);
        remaining <= {1'b0, req_count} + 5'd1;
        exp_q     <= q_in;
        {j, k}    <= op_jk(op_t'(req_op));
      end else if (state == ST_DRIVE) begin
        remaining <= remaining - 5'd1;
        exp_q     <= exp_q_nxt;
        {j, k}    <= (remaining <= 5'd1) ? 2'b00 : op_jk(op_q);
      end else begin
        {j, k}    <= 2'b00;
      end
      if (accept)
        err <= 1'b0;
      else if (mismatch)
        err <= 1'b1;
      if (mismatch)
        err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_jk_driver.sv
// Directed bench for jk_driver with a behavioural JK flip-flop in the loop.
module tb_jk_driver;
  import jk_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_count;
  logic       j, k, q_in, done, err;
  logic [7:0] err_cnt;
  logic       q;
  logic       force_zero;
  logic       seen_done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // The JK flip-flop being driven.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign q_in = force_zero ? 1'b0 : q;

  jk_driver #(.ERR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_count (req_count),
    .j         (j),
    .k         (k),
    .q_in      (q_in),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_jk(input logic [1:0] op);
    case (op)
      2'b00:   return 2'b00;
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic run(input string tag, input logic [1:0] op, input logic [3:0] cnt,
                     input logic [15:0] qexp, input logic exp_err);
    int n;
    n = int'(cnt) + 1;
    req_valid = 1'b1;
    req_op    = op;
    req_count = cnt;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_ready_busy"}, req_ready, 1'b0);
    chk({tag, "_jk_first"}, {j, k}, exp_jk(op));
    chk({tag, "_err_clr"}, err, 1'b0);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk($sformatf("%s_q%0d", tag, i), q, qexp[i-1]);
      chk($sformatf("%s_nodone%0d", tag, i), done, 1'b0);
      if (i < n) chk($sformatf("%s_jk%0d", tag, i), {j, k}, exp_jk(op));
      else       chk({tag, "_jk_drain"}, {j, k}, 2'b00);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_err"}, err, exp_err);
    @(negedge clk);
    chk({tag, "_done_low"}, done, 1'b0);
    chk({tag, "_ready_idle"}, req_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_count = 4'd0;
    force_zero = 1'b0;
    seen_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_jk", {j, k}, 2'b00);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_errcnt", err_cnt, 8'd0);
    rst = 1'b0;

    // SET x1 accepted on the first edge out of reset
    run("set1", OP_SET, 4'd0, 16'h0001, 1'b0);
    chk("set1_q", q, 1'b1);

    // TOGGLE x4 from q=1: 0,1,0,1
    run("tog4", OP_TOGGLE, 4'd3, 16'b1010, 1'b0);
    chk("tog4_errcnt", err_cnt, 8'd0);

    // RESET x2 then HOLD x3
    run("rst2", OP_RESET, 4'd1, 16'h0000, 1'b0);
    run("hold3", OP_HOLD, 4'd2, 16'h0000, 1'b0);
    chk("hold3_errcnt", err_cnt, 8'd0);

    // Returned Q stuck at 0 during SET x4
    force_zero = 1'b1;
    run("fault", OP_SET, 4'd3, 16'h000F, 1'b1);
    force_zero = 1'b0;
    chk("fault_errcnt", err_cnt, 8'd4);
    chk("fault_err_held", err, 1'b1);
    run("fault_clr", OP_SET, 4'd0, 16'h0001, 1'b0);
    chk("fault_clr_errcnt", err_cnt, 8'd4);

    // Asynchronous reset in the middle of TOGGLE x16
    req_valid = 1'b1;
    req_op    = OP_TOGGLE;
    req_count = 4'd15;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_jk_pre", {j, k}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("abort_jk", {j, k}, 2'b00);
    chk("abort_ready", req_ready, 1'b1);
    chk("abort_err", err, 1'b0);
    chk("abort_errcnt", err_cnt, 8'd0);
    chk("abort_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", seen_done, 1'b0);
    run("after_abort", OP_SET, 4'd0, 16'h0001, 1'b0);

    // req_valid held high: SET x2 then RESET x2, 5 cycles apart
    req_valid = 1'b1;
    req_op    = OP_SET;
    req_count = 4'd1;
    @(negedge clk);
    chk("b2b_jk1", {j, k}, 2'b10);
    chk("b2b_ready1", req_ready, 1'b0);
    req_op = OP_RESET;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_busy%0d", i), req_ready, 1'b0);
      if (i == 1) chk("b2b_ignored", {j, k}, 2'b10);
      if (i == 3) chk("b2b_done1", done, 1'b1);
    end
    @(negedge clk);
    chk("b2b_idle", req_ready, 1'b1);
    chk("b2b_jk_idle", {j, k}, 2'b00);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_accept2", req_ready, 1'b0);
    chk("b2b_jk2", {j, k}, 2'b01);
    repeat (3) @(negedge clk);
    chk("b2b_done2", done, 1'b1);
    chk("b2b_q2", q, 1'b0);
    chk("b2b_err", err, 1'b0);
    @(negedge clk);
    chk("b2b_end_ready", req_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
